// File: rtl/stack_ctrl_if.sv
// Requester-side bus of stack_ctrl: two req/done ports (A = core, B = interrupt)
// plus the shared completion status and popped data.
interface stack_ctrl_if #(
    parameter int WIDTH = 8
);
    // Handshake: a requester raises req[x] with op/wdata stable and holds it until
    // done[x] pulses for one cycle; err and rdata are valid in that same cycle.
    // The requester must drop req (or present a new request) by the edge after done.
    logic [1:0]       req;
    logic             op_a;
    logic             op_b;
    logic [WIDTH-1:0] wdata_a;
    logic [WIDTH-1:0] wdata_b;
    logic [1:0]       done;
    logic             err;
    logic [WIDTH-1:0] rdata;

    modport master (
        output req, op_a, op_b, wdata_a, wdata_b,
        input  done, err, rdata
    );

    modport slave (
        input  req, op_a, op_b, wdata_a, wdata_b,
        output done, err, rdata
    );
endinterface

// File: rtl/stack_ctrl.sv
// Sequencing/arbitration controller for the shared data stack: occupancy tracking,
// overflow/underflow rejection, stack drive. Define STACK_CTRL_RR_EN for round-robin.
module stack_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             clr,
    stack_ctrl_if.slave      bus,
    output logic             stk_en,
    output logic [1:0]       stk_con,
    output logic [WIDTH-1:0] stk_din,
    input  logic [WIDTH-1:0] stk_dout,
    output logic             stk_clr,
    output logic [DEPTH:0]   count,
    output logic             full,
    output logic             empty,
    output logic             err_ovf,
    output logic             err_unf,
    input  logic             err_clr,
    // 0 INIT, 1 IDLE, 2 PUSH, 3 POP, 4 POPW, 5 DONE
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_PUSH = 3'd2,
        S_POP  = 3'd3,
        S_POPW = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [DEPTH:0] CAP = {1'b1, {DEPTH{1'b0}}};
    localparam logic [DEPTH:0] ONE = {{DEPTH{1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             id_q, id_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [DEPTH:0]   count_q, count_d;
    logic             full_q, empty_q;
    logic             ovf_q, unf_q;
    logic             ovf_set, unf_set;
    logic             accept;
    logic             win_b;
    logic             sel_op;
    logic [WIDTH-1:0] sel_wdata;

`ifdef STACK_CTRL_RR_EN
    logic last_b_q;

    // On a tie the requester not served last wins; reset value lets A win first.
    always_comb begin
        win_b = bus.req[1] && (!bus.req[0] || !last_b_q);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            last_b_q <= 1'b1;
        end else if (accept) begin
            last_b_q <= win_b;
        end
    end
`else
    always_comb begin
        win_b = bus.req[1];
    end
`endif

    always_comb begin
        sel_op    = win_b ? bus.op_b : bus.op_a;
        sel_wdata = win_b ? bus.wdata_b : bus.wdata_a;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        accept  = 1'b0;
        stk_en  = 1'b0;
        stk_con = 2'b10;
        stk_din = '0;
        stk_clr = 1'b1;
        bus.done = 2'b00;
        case (state_q)
            S_INIT: begin
                stk_clr = 1'b0;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (|bus.req) begin
                    accept  = 1'b1;
                    id_d    = win_b;
                    op_d    = sel_op;
                    wdata_d = sel_wdata;
                    if (!sel_op && full_q) begin
                        err_d   = 1'b1;
                        ovf_set = 1'b1;
                        state_d = S_DONE;
                    end else if (sel_op && empty_q) begin
                        err_d   = 1'b1;
                        unf_set = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = sel_op ? S_POP : S_PUSH;
                    end
                end
            end
            S_PUSH: begin
                stk_en  = 1'b1;
                stk_con = 2'b00;
                stk_din = wdata_q;
                count_d = count_q + ONE;
                state_d = S_DONE;
            end
            S_POP: begin
                stk_en  = 1'b1;
                stk_con = 2'b01;
                count_d = count_q - ONE;
                state_d = S_POPW;
            end
            // The stack registers its output on the pop edge, so data is valid here.
            S_POPW: begin
                rdata_d = stk_dout;
                state_d = S_DONE;
            end
            S_DONE: begin
                bus.done = id_q ? 2'b10 : 2'b01;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_INIT;
            id_q    <= 1'b0;
            op_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            count_q <= count_d;
            full_q  <= (count_d == CAP);
            empty_q <= (count_d == '0);
            // A clear request wins over a same-cycle rejection.
            ovf_q   <= err_clr ? 1'b0 : (ovf_q | ovf_set);
            unf_q   <= err_clr ? 1'b0 : (unf_q | unf_set);
        end
    end

    always_comb begin
        bus.err   = err_q;
        bus.rdata = rdata_q;
        count     = count_q;
        full      = full_q;
        empty     = empty_q;
        err_ovf   = ovf_q;
        err_unf   = unf_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural stack, transaction-level model checked every
// cycle, plus literal expectations pinning the model.
module tb_stack_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             err_clr = 1'b0;
    logic             stk_en;
    logic [1:0]       stk_con;
    logic [WIDTH-1:0] stk_din;
    logic [WIDTH-1:0] stk_dout;
    logic             stk_clr;
    logic [DEPTH:0]   count;
    logic             full, empty, err_ovf, err_unf;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    stack_ctrl_if #(.WIDTH(WIDTH)) bus ();

    stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .clr       (clr),
        .bus       (bus),
        .stk_en    (stk_en),
        .stk_con   (stk_con),
        .stk_din   (stk_din),
        .stk_dout  (stk_dout),
        .stk_clr   (stk_clr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf),
        .err_clr   (err_clr),
        .dbg_state (dbg_state)
    );

    // Behavioural stack: registered data_out on pop, synchronous active-low clear.
    logic [WIDTH-1:0] mem [8];
    logic [3:0]       sp;
    always @(posedge clk) begin
        if (!stk_clr) begin
            sp       <= 4'd0;
            stk_dout <= '0;
        end else if (stk_en && stk_con == 2'b00) begin
            mem[sp[2:0]] <= stk_din;
            sp           <= sp + 4'd1;
        end else if (stk_en && stk_con == 2'b01) begin
            stk_dout <= mem[sp[2:0] - 3'd1];
            sp       <= sp - 4'd1;
        end
    end

    // Model: expected stack contents and expected per-cycle outputs.
    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf = 1'b0, m_unf = 1'b0, m_err = 1'b0;
    logic [WIDTH-1:0] m_rdata = '0, m_din = '0;
    logic [1:0]       m_done = 2'b00, m_con = 2'b10;
    logic             m_en = 1'b0, m_stkclr = 1'b0;
    int               errors = 0;
    int               checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        check("count", count, exp_q.size());
        check("full", full, exp_q.size() == 8);
        check("empty", empty, exp_q.size() == 0);
        check("err_ovf", err_ovf, m_ovf);
        check("err_unf", err_unf, m_unf);
        check("done", bus.done, m_done);
        check("rdata", bus.rdata, m_rdata);
        check("stk_en", stk_en, m_en);
        check("stk_con", stk_con, m_en ? m_con : 2'b10);
        check("stk_clr", stk_clr, m_stkclr);
        if (m_done != 2'b00) check("err", bus.err, m_err);
        if (m_en && m_con == 2'b00) check("stk_din", stk_din, m_din);
    end

    task automatic drop(input int id);
        if (id == 0) bus.req[0] = 1'b0;
        else         bus.req[1] = 1'b0;
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the next idle cycle.
    task automatic do_op(input int id, input logic op, input logic [WIDTH-1:0] d, input logic fclr);
        logic [WIDTH-1:0] v;
        logic [1:0]       onehot;
        bit               rej;
        onehot = (id == 0) ? 2'b01 : 2'b10;
        rej    = op ? (exp_q.size() == 0) : (exp_q.size() == 8);
        if (id == 0) begin bus.op_a = op; bus.wdata_a = d; bus.req[0] = 1'b1; end
        else         begin bus.op_b = op; bus.wdata_b = d; bus.req[1] = 1'b1; end
        err_clr = fclr;
        @(negedge clk);
        err_clr = 1'b0;
        if (fclr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (rej) begin
            if (!fclr) begin
                if (op) m_unf = 1'b1;
                else    m_ovf = 1'b1;
            end
            m_done = onehot; m_err = 1'b1; drop(id);
            @(negedge clk);
            m_done = 2'b00;
        end else if (!op) begin
            m_en = 1'b1; m_con = 2'b00; m_din = d;
            @(negedge clk);
            m_en = 1'b0; exp_q.push_back(d);
            m_done = onehot; m_err = 1'b0; drop(id);
            @(negedge clk);
            m_done = 2'b00;
        end else begin
            m_en = 1'b1; m_con = 2'b01;
            @(negedge clk);
            m_en = 1'b0; v = exp_q.pop_back();
            @(negedge clk);
            m_rdata = v; m_done = onehot; m_err = 1'b0; drop(id);
            @(negedge clk);
            m_done = 2'b00;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0; m_done = 2'b00;
        m_en = 1'b0; m_stkclr = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        clr = 1'b0; bus.req = 2'b00; model_reset();
        repeat (cycles) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        m_stkclr = 1'b1;
    endtask

    task automatic flag_clear();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_top;
        int               win, lose;
        bus.req = 2'b00; bus.op_a = 1'b0; bus.op_b = 1'b0;
        bus.wdata_a = '0; bus.wdata_b = '0;

        // Reset and idle
        @(negedge clk); #2;
        check("rst_state", dbg_state, 3'd0);
        check("rst_stk_clr", stk_clr, 1'b0);
        check("rst_stk_din", stk_din, 8'h00);
        check("rst_err", bus.err, 1'b0);
        @(negedge clk);
        do_reset(1);
        #2;
        check("idle_state", dbg_state, 3'd1);
        check("idle_empty", empty, 1'b1);
        check("idle_con", stk_con, 2'b10);

        // A: push 0x11, 0x22, pop
        do_op(0, 1'b0, 8'h11, 1'b0);
        do_op(0, 1'b0, 8'h22, 1'b0);
        do_op(0, 1'b1, 8'h00, 1'b0);
        #2;
        check("pop_rdata", bus.rdata, 8'h22);
        check("pop_count", count, 4'd1);
        do_op(0, 1'b1, 8'h00, 1'b0);

        // Underflow
        do_op(0, 1'b1, 8'h00, 1'b0);
        #2;
        check("unf_flag", err_unf, 1'b1);
        check("unf_rdata_held", bus.rdata, 8'h11);
        flag_clear();

        // Fill, overflow, clear, clear-vs-set priority
        for (int i = 0; i < 8; i++) do_op(i % 2, 1'b0, 8'h30 + 8'(i), 1'b0);
        do_op(0, 1'b0, 8'h99, 1'b0);
        #2;
        check("ovf_flag", err_ovf, 1'b1);
        check("ovf_count", count, 4'd8);
        flag_clear();
        #2;
        check("ovf_cleared", err_ovf, 1'b0);
        do_op(1, 1'b0, 8'h77, 1'b1);
        #2;
        check("clr_priority", err_ovf, 1'b0);
        do_op(1, 1'b1, 8'h00, 1'b0);
        #2;
        check("lifo_top", bus.rdata, 8'h37);
        for (int i = 0; i < 7; i++) do_op(i % 2, 1'b1, 8'h00, 1'b0);
        #2;
        check("drain_rdata", bus.rdata, 8'h30);

        // Simultaneous requests right after reset
        do_reset(2);
`ifdef STACK_CTRL_RR_EN
        win = 0; exp_top = 8'hBB;
`else
        win = 1; exp_top = 8'hAA;
`endif
        lose = 1 - win;
        if (lose == 0) begin bus.op_a = 1'b0; bus.wdata_a = 8'hAA; bus.req[0] = 1'b1; end
        else           begin bus.op_b = 1'b0; bus.wdata_b = 8'hBB; bus.req[1] = 1'b1; end
        do_op(win, 1'b0, (win == 0) ? 8'hAA : 8'hBB, 1'b0);
        do_op(lose, 1'b0, (lose == 0) ? 8'hAA : 8'hBB, 1'b0);
        do_op(0, 1'b1, 8'h00, 1'b0);
        #2;
        check("arb_top", bus.rdata, exp_top);
        do_op(1, 1'b1, 8'h00, 1'b0);

        // clr during POPW
        do_op(0, 1'b0, 8'h5A, 1'b0);
        bus.op_a = 1'b1; bus.req[0] = 1'b1;
        @(negedge clk);
        m_en = 1'b1; m_con = 2'b01;
        @(negedge clk);
        m_en = 1'b0; void'(exp_q.pop_back());
        #2;
        check("popw_state", dbg_state, 3'd4);
        clr = 1'b0; bus.req = 2'b00; model_reset();
        #1;
        check("clr_state", dbg_state, 3'd0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        m_stkclr = 1'b1;
        do_op(0, 1'b1, 8'h00, 1'b0);
        #2;
        check("post_clr_unf", err_unf, 1'b1);
        check("post_clr_count", count, 4'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
